mesh_router_sync: RTL and testbench

Clocked, parametrised successor to the click-based corner router: a five-port (local, north, east, south, west) single-flit mesh router with per-input FIFOs, dimension-ordered XY routing, per-output arbitration and registered valid/ready outputs. It replaces the asynchronous req/ack fork/demux/arbiter fabric with one synchronous block. It is instantiated once per mesh tile, and its port indices match the tile wiring.

---
 rtl/mesh_router_sync.sv | 172 +++++++++++++++++
 tb/tb_mesh_router_sync.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_router_sync.sv
// mesh_router_sync: five-port single-flit XY mesh router with per-input FIFOs and registered outputs.
// Optional macro ROUTER_RR_ARB_EN selects round-robin output arbitration; undefined gives fixed priority local > N > E > S > W.
module mesh_router_sync #(
    parameter int N     = 32,
    parameter int MAXX  = 4,
    parameter int MAXY  = 4,
    parameter int SRCX  = 2,
    parameter int SRCY  = 2,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         in_valid,
    output logic [4:0]         in_ready,
    input  logic [4:0][N-1:0]  in_data,
    output logic [4:0]         out_valid,
    input  logic [4:0]         out_ready,
    output logic [4:0][N-1:0]  out_data
);
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
    localparam logic [MAXX-1:0] SRC_X   = MAXX'(SRCX);
    localparam logic [MAXY-1:0] SRC_Y   = MAXY'(SRCY);

    localparam logic [4:0] TO_LOCAL = 5'b00001;
    localparam logic [4:0] TO_NORTH = 5'b00010;
    localparam logic [4:0] TO_EAST  = 5'b00100;
    localparam logic [4:0] TO_SOUTH = 5'b01000;
    localparam logic [4:0] TO_WEST  = 5'b10000;

    logic [N-1:0]      mem_q [5][DEPTH];
    logic [N-1:0]      mem_d [5][DEPTH];
    logic [4:0][AW:0]  wr_ptr_q, wr_ptr_d;
    logic [4:0][AW:0]  rd_ptr_q, rd_ptr_d;
    logic              rdy_en_q, rdy_en_d;
    logic [4:0]        out_valid_q, out_valid_d;
    logic [4:0][N-1:0] out_data_q, out_data_d;

    logic [4:0]        empty, full, can_accept, push, pop;
    logic [N-1:0]      head [5];
    logic [4:0][4:0]   route;
    logic [4:0][4:0]   req;
    logic [4:0][4:0]   gnt;
`ifdef ROUTER_RR_ARB_EN
    logic [4:0][4:0]   rr_q, rr_d;
    logic [4:0]        masked, above;
`endif

    // Dimension-ordered XY: resolve x completely before looking at y.
    function automatic logic [4:0] route_of(input logic [N-1:0] flit);
        logic [MAXX-1:0] dx;
        logic [MAXY-1:0] dy;
        dx = flit[N-1 -: MAXX];
        dy = flit[N-MAXX-1 -: MAXY];
        if (dx > SRC_X)      route_of = TO_EAST;
        else if (dx < SRC_X) route_of = TO_WEST;
        else if (dy > SRC_Y) route_of = TO_NORTH;
        else if (dy < SRC_Y) route_of = TO_SOUTH;
        else                 route_of = TO_LOCAL;
    endfunction

    function automatic logic [4:0] lowest_bit(input logic [4:0] x);
        lowest_bit = x & (~x + 5'd1);
    endfunction

    // rst only gates the in_ready output; push relies on the flops being held in reset instead.
    always_comb begin
        in_ready   = '0;
        can_accept = '0;
        push       = '0;
        empty      = '0;
        full       = '0;
        route      = '0;
        for (int i = 0; i < 5; i++) begin
            head[i]       = mem_q[i][rd_ptr_q[i][AW-1:0]];
            empty[i]      = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]       = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                            (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            can_accept[i] = rdy_en_q && !full[i];
            in_ready[i]   = rst && can_accept[i];
            push[i]       = in_valid[i] && can_accept[i];
            route[i]      = route_of(head[i]);
        end
    end

    always_comb begin
        req = '0;
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                req[o][i] = !empty[i] && route[i][o];
            end
        end
    end

    // Every head requests a single output, so per-output grants never collide on a pop.
    always_comb begin
        gnt         = '0;
        pop         = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
`ifdef ROUTER_RR_ARB_EN
        rr_d        = rr_q;
        masked      = '0;
        above       = '0;
`endif
        for (int o = 0; o < 5; o++) begin
            if ((req[o] != 5'd0) && (!out_valid_q[o] || out_ready[o])) begin
`ifdef ROUTER_RR_ARB_EN
                masked  = req[o] & rr_q[o];
                gnt[o]  = (masked != 5'd0) ? lowest_bit(masked) : lowest_bit(req[o]);
                above   = {gnt[o][3:0], 1'b0} - 5'd1;
                rr_d[o] = ~above;
`else
                gnt[o]  = lowest_bit(req[o]);
`endif
                out_valid_d[o] = 1'b1;
                out_data_d[o]  = '0;
                for (int i = 0; i < 5; i++) begin
                    if (gnt[o][i]) out_data_d[o] = head[i];
                end
                pop = pop | gnt[o];
            end else if (out_ready[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rdy_en_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i][AW-1:0]] = in_data[i];
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
            end
            if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdy_en_q    <= 1'b0;
            out_valid_q <= '0;
            out_data_q  <= '0;
`ifdef ROUTER_RR_ARB_EN
            rr_q        <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rdy_en_q    <= rdy_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
`ifdef ROUTER_RR_ARB_EN
            rr_q        <= rr_d;
`endif
        end
    end

    // Storage needs no reset: emptiness comes entirely from the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mesh_router_sync.sv
// tb_mesh_router_sync: directed vector table plus hand-written multi-cycle sequences for mesh_router_sync.
module tb_mesh_router_sync;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        in_valid;
    logic [4:0]        in_ready;
    logic [4:0][N-1:0] in_data;
    logic [4:0]        out_valid;
    logic [4:0]        out_ready;
    logic [4:0][N-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          in_port;
        logic [31:0] flit;
        int          out_port;
    } vec_t;

    vec_t        vecs [10];
    logic [4:0]  exp_oh;
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];

    mesh_router_sync #(
        .N(N), .MAXX(4), .MAXY(4), .SRCX(2), .SRCY(2), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one flit for exactly one cycle; returns one cycle after acceptance.
    task automatic applyStimulus(input int port, input logic [31:0] flit);
        in_valid       = '0;
        in_valid[port] = 1'b1;
        in_data[port]  = flit;
        tick();
        in_valid = '0;
    endtask

    initial begin
        int          accepted;
        bit          acc_now;
        int          sent;
        int          recv;
        logic [31:0] exp_flit;
        int          p;
        int          k;

        vecs[0] = '{in_port: 0, flit: 32'h3200_00AA, out_port: 2};
        vecs[1] = '{in_port: 4, flit: 32'h2300_0001, out_port: 1};
        vecs[2] = '{in_port: 1, flit: 32'h2200_0002, out_port: 0};
        vecs[3] = '{in_port: 0, flit: 32'h1200_0003, out_port: 4};
        vecs[4] = '{in_port: 0, flit: 32'h2100_0004, out_port: 3};
        vecs[5] = '{in_port: 2, flit: 32'hF000_0005, out_port: 2};
        vecs[6] = '{in_port: 3, flit: 32'h0F00_0006, out_port: 4};
        vecs[7] = '{in_port: 1, flit: 32'h2F00_0007, out_port: 1};
        vecs[8] = '{in_port: 4, flit: 32'h2000_0008, out_port: 3};
        vecs[9] = '{in_port: 2, flit: 32'h2200_0009, out_port: 0};

        rst       = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;

        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
        checkOutput("reset_out_data_e", out_data[2], 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("in_ready_before_first_edge", 32'(in_ready), 32'h0);
        tick();
        checkOutput("in_ready_after_first_edge", 32'(in_ready), 32'h1F);

        // Single-flit routing table: silent at t+1, only the expected port valid at t+2, cleared at t+3.
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].in_port, vecs[v].flit);
            checkOutput($sformatf("vec%0d_t1_valid", v), 32'(out_valid), 32'h0);
            tick();
            exp_oh = 5'b00001 << vecs[v].out_port;
            checkOutput($sformatf("vec%0d_t2_valid", v), 32'(out_valid), 32'(exp_oh));
            checkOutput($sformatf("vec%0d_t2_data", v), out_data[vecs[v].out_port], vecs[v].flit);
            tick();
            checkOutput($sformatf("vec%0d_t3_valid", v), 32'(out_valid), 32'h0);
        end

        // Two simultaneous injections heading to different outputs.
        in_valid   = 5'b10010;
        in_data[4] = 32'h2300_0001;
        in_data[1] = 32'h2200_0002;
        tick();
        in_valid = '0;
        checkOutput("dual_t1_valid", 32'(out_valid), 32'h0);
        tick();
        checkOutput("dual_t2_valid", 32'(out_valid), 32'h03);
        checkOutput("dual_t2_data_n", out_data[1], 32'h2300_0001);
        checkOutput("dual_t2_data_local", out_data[0], 32'h2200_0002);
        tick();

        // Backpressure on E: FIFO plus output register absorb DEPTH+1 flits.
        out_ready[2] = 1'b0;
        accepted     = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'h3200_0100 + 32'(accepted);
            @(negedge clk);
            acc_now = in_ready[0];
            tick();
            if (acc_now) accepted++;
        end
        in_valid = '0;
        checkOutput("bp_accepted", 32'(accepted), 32'(DEPTH + 1));
        checkOutput("bp_in_ready_low", 32'(in_ready[0]), 32'h0);
        out_ready[2] = 1'b1;
        for (int j = 0; j < DEPTH + 1; j++) begin
            checkOutput($sformatf("bp_drain%0d_valid", j), 32'(out_valid[2]), 32'h1);
            checkOutput($sformatf("bp_drain%0d_data", j), out_data[2], 32'h3200_0100 + 32'(j));
            tick();
        end
        checkOutput("bp_drained_valid", 32'(out_valid[2]), 32'h0);
        checkOutput("bp_in_ready_back", 32'(in_ready[0]), 32'h1);

        // Four ports each send four flits to local; record output order.
        out_ready = '1;
        got_q.delete();
        for (int kk = 0; kk < 4; kk++) begin
            in_valid = 5'b11110;
            for (int pp = 1; pp < 5; pp++) begin
                in_data[pp] = 32'h2200_0000 | 32'(pp << 8) | 32'(kk);
            end
            tick();
            if (out_valid[0]) got_q.push_back(out_data[0]);
        end
        in_valid = '0;
        for (int c = 0; c < 40 && got_q.size() < 16; c++) begin
            tick();
            if (out_valid[0]) got_q.push_back(out_data[0]);
        end
        checkOutput("arb_count", 32'(got_q.size()), 32'd16);
        for (int j = 0; j < got_q.size() && j < 16; j++) begin
`ifdef ROUTER_RR_ARB_EN
            p = 1 + (j % 4);
            k = j / 4;
`else
            p = 1 + (j / 4);
            k = j % 4;
`endif
            exp_flit = 32'h2200_0000 | 32'(p << 8) | 32'(k);
            checkOutput($sformatf("arb_order%0d", j), got_q[j], exp_flit);
        end
        tick();

        // Asynchronous reset while E holds a stalled flit and more are queued.
        out_ready[2] = 1'b0;
        for (int kk = 0; kk < 3; kk++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 32'h3200_0200 + 32'(kk);
            tick();
        end
        in_valid = '0;
        tick();
        checkOutput("rst_pre_valid_e", 32'(out_valid[2]), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_async_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_async_in_ready", 32'(in_ready), 32'h0);
        checkOutput("rst_async_out_data_e", out_data[2], 32'h0);
        tick();
        #2;
        rst       = 1'b1;
        out_ready = '1;
        #1;
        checkOutput("rst_release_in_ready", 32'(in_ready), 32'h0);
        tick();
        checkOutput("rst_first_edge_in_ready", 32'(in_ready), 32'h1F);
        checkOutput("rst_no_stale_a", 32'(out_valid), 32'h0);
        applyStimulus(0, 32'h3200_00BB);
        checkOutput("rst_no_stale_b", 32'(out_valid), 32'h0);
        tick();
        checkOutput("rst_new_valid", 32'(out_valid), 32'h04);
        checkOutput("rst_new_data", out_data[2], 32'h3200_00BB);
        tick();

        // Pointer wrap: 3*DEPTH flits local->E with random valid and ready.
        sent = 0;
        recv = 0;
        exp_q.delete();
        for (int c = 0; c < 400 && recv < 3 * DEPTH; c++) begin
            out_ready[2] = 1'($urandom_range(0, 1));
            if (sent < 3 * DEPTH) begin
                in_valid[0] = 1'($urandom_range(0, 1));
                in_data[0]  = 32'h3200_0300 + 32'(sent);
            end else begin
                in_valid[0] = 1'b0;
            end
            @(negedge clk);
            if (out_valid[2] && out_ready[2]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL wrap_extra: got 0x%08h, expected no flit", out_data[2]);
                end else begin
                    checkOutput($sformatf("wrap_flit%0d", recv), out_data[2], exp_q.pop_front());
                end
                recv++;
            end
            if (in_valid[0] && in_ready[0]) begin
                exp_q.push_back(in_data[0]);
                sent++;
            end
            tick();
        end
        in_valid = '0;
        checkOutput("wrap_count", 32'(recv), 32'(3 * DEPTH));
        checkOutput("wrap_leftover", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
